// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-add multiply/accumulate for one PE,
//               feeding the partial-product and final-data registers.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    acc_clr,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic [2*DATA_WIDTH-1:0] pp_data,
  output logic                    pp_cin,
  output logic                    en_PPReg,
  output logic [2*DATA_WIDTH:0]   fd_data,
  output logic                    en_FDReg,
  output logic                    done
);

  localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int c_PW    = 2 * DATA_WIDTH;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ITER  = 2'd1;
  localparam logic [1:0] c_FINAL = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic [DATA_WIDTH-1:0] r_a,       w_a_nxt;
  logic [DATA_WIDTH-1:0] r_b,       w_b_nxt;
  logic [c_PW:0]         r_acc,     w_acc_nxt;
  logic [c_CNT_W-1:0]    r_cnt,     w_cnt_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic [c_PW-1:0]       r_pp_data, w_pp_data_nxt;
  logic                  r_pp_cin,  w_pp_cin_nxt;
  logic                  r_en_pp,   w_en_pp_nxt;
  logic [c_PW:0]         r_fd_data, w_fd_data_nxt;
  logic                  r_en_fd,   w_en_fd_nxt;
  logic                  r_done,    w_done_nxt;

  logic [c_PW-1:0]       w_addend;
  logic [c_PW:0]         w_sum;
  logic                  w_last;

  // Multiplier bit selects whether the shifted multiplicand joins the sum
  assign w_addend = r_b[r_cnt] ? ({{DATA_WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_sum    = {1'b0, r_acc[c_PW-1:0]} + {1'b0, w_addend};
  assign w_last   = (r_cnt == c_CNT_W'(DATA_WIDTH - 1));

  // State and all datapath/output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pp_data <= '0;
      r_pp_cin  <= 1'b0;
      r_en_pp   <= 1'b0;
      r_fd_data <= '0;
      r_en_fd   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_pp_data <= w_pp_data_nxt;
      r_pp_cin  <= w_pp_cin_nxt;
      r_en_pp   <= w_en_pp_nxt;
      r_fd_data <= w_fd_data_nxt;
      r_en_fd   <= w_en_fd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_ITER;
      c_ITER:  if (w_last) w_state_nxt = c_FINAL;
      c_FINAL: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_pp_data_nxt = r_pp_data;
    w_pp_cin_nxt  = r_pp_cin;
    w_en_pp_nxt   = 1'b0;
    w_fd_data_nxt = r_fd_data;
    w_en_fd_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_a_nxt    = op_a;
          w_b_nxt    = op_b;
          w_cnt_nxt  = '0;
          w_busy_nxt = 1'b1;
          if (acc_clr) w_acc_nxt = '0;
        end
      end
      c_ITER: begin
        // Carry beyond the product width is kept only as a sticky flag
        w_acc_nxt     = {r_acc[c_PW] | w_sum[c_PW], w_sum[c_PW-1:0]};
        w_pp_data_nxt = w_sum[c_PW-1:0];
        w_pp_cin_nxt  = w_sum[c_PW];
        w_en_pp_nxt   = 1'b1;
        w_cnt_nxt     = r_cnt + 1'b1;
      end
      c_FINAL: begin
        w_fd_data_nxt = r_acc;
        w_en_fd_nxt   = 1'b1;
        w_done_nxt    = 1'b1;
        w_busy_nxt    = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign busy     = r_busy;
  assign pp_data  = r_pp_data;
  assign pp_cin   = r_pp_cin;
  assign en_PPReg = r_en_pp;
  assign fd_data  = r_fd_data;
  assign en_FDReg = r_en_fd;
  assign done     = r_done;

endmodule
`default_nettype wire
